// File: rtl/seq_div_if.sv
// seq_div_if: request/result bundle between operand fetch and the DIV/IDIV unit
interface seq_div_if #(parameter int W = 8);
    logic           start;
    logic           signed_op;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic           div_err;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    modport master (output start, signed_op, dividend, divisor,
                    input  busy, done, div_err, quotient, remainder);
    modport slave  (input  start, signed_op, dividend, divisor,
                    output busy, done, div_err, quotient, remainder);
endinterface

// File: rtl/seq_div_unit.sv
// seq_div_unit: iterative 8086 DIV/IDIV, AX / r8 -> AL quotient, AH remainder.
// Radix-2 restoring division on magnitudes, then sign fix and range check.
module seq_div_unit #(parameter int W = 8) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);
    localparam int CW = $clog2(2*W);
    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;
    state_t         state;
    logic           sop, zerr, sd, sv;
    logic [2*W-1:0] dvd, quo;
    logic [W-1:0]   dvs;
    logic [W:0]     dmag, rem;
    logic [CW-1:0]  cnt;
    logic [W+1:0]   trial;
    logic           ovf;
    logic [W-1:0]   q_fix, r_fix;
    // IDIV traps on -128 as well, so any magnitude above 127 overflows
    always_comb begin
        trial = {rem, quo[2*W-1]} - {1'b0, dmag};
        ovf   = sop ? |quo[2*W-1:W-1] : |quo[2*W-1:W];
        q_fix = (sd ^ sv) ? -quo[W-1:0] : quo[W-1:0];
        r_fix = sd ? -rem[W-1:0] : rem[W-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sop           <= 1'b0;
            zerr          <= 1'b0;
            sd            <= 1'b0;
            sv            <= 1'b0;
            dvd           <= '0;
            dvs           <= '0;
            quo           <= '0;
            dmag          <= '0;
            rem           <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.div_err   <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sop      <= bus.signed_op;
                    dvd      <= bus.dividend;
                    dvs      <= bus.divisor;
                    bus.busy <= 1'b1;
                    state    <= SETUP;
                end
                SETUP: begin
                    zerr  <= dvs == '0;
                    sd    <= sop & dvd[2*W-1];
                    sv    <= sop & dvs[W-1];
                    quo   <= (sop & dvd[2*W-1]) ? -dvd : dvd;
                    dmag  <= (sop & dvs[W-1]) ? -{dvs[W-1], dvs} : {1'b0, dvs};
                    rem   <= '0;
                    cnt   <= CW'(2*W-1);
                    state <= (dvs == '0) ? FIX : ITER;
                end
                ITER: begin
                    rem   <= trial[W+1] ? {rem[W-1:0], quo[2*W-1]} : trial[W:0];
                    quo   <= {quo[2*W-2:0], ~trial[W+1]};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? FIX : ITER;
                end
                FIX: begin
                    bus.div_err <= zerr | ovf;
                    if (!(zerr | ovf)) begin
                        bus.quotient  <= q_fix;
                        bus.remainder <= r_fix;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit: directed DIV/IDIV vectors with hand-computed results.
module tb_seq_div_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_div_if #(.W(8)) bus ();
    seq_div_unit #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request; lat = edges from acceptance to done, bcnt = busy samples
    task automatic do_op(input logic s, input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = s; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.div_err); end
        checks++; if (bus.quotient !== 8'h00) begin errors++; $display("FAIL rst_q got %h exp 00", bus.quotient); end
        checks++; if (bus.remainder !== 8'h00) begin errors++; $display("FAIL rst_r got %h exp 00", bus.remainder); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_div;
        int lat, bc;
        do_op(1'b0, 16'h004B, 8'h19, lat, bc);
        checks++; if (lat !== 18) begin errors++; $display("FAIL div_lat got %0d exp 18", lat); end
        checks++; if (bc !== 18) begin errors++; $display("FAIL div_busy got %0d exp 18", bc); end
        checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL div_q got %h exp 03", bus.quotient); end
        checks++; if (bus.remainder !== 8'h00) begin errors++; $display("FAIL div_r got %h exp 00", bus.remainder); end
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL div_err got %b exp 0", bus.div_err); end
    endtask

    task automatic test_idiv;
        int lat, bc;
        do_op(1'b1, 16'hFFB4, 8'h19, lat, bc);
        checks++; if (lat !== 18) begin errors++; $display("FAIL idiv1_lat got %0d exp 18", lat); end
        checks++; if (bus.quotient !== 8'hFD) begin errors++; $display("FAIL idiv1_q got %h exp fd", bus.quotient); end
        checks++; if (bus.remainder !== 8'hFF) begin errors++; $display("FAIL idiv1_r got %h exp ff", bus.remainder); end
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL idiv1_err got %b exp 0", bus.div_err); end
        do_op(1'b1, 16'hFFB4, 8'hE7, lat, bc);
        checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL idiv2_q got %h exp 03", bus.quotient); end
        checks++; if (bus.remainder !== 8'hFF) begin errors++; $display("FAIL idiv2_r got %h exp ff", bus.remainder); end
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL idiv2_err got %b exp 0", bus.div_err); end
    endtask

    task automatic test_overflow;
        int lat, bc;
        do_op(1'b0, 16'h1000, 8'h10, lat, bc);
        checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL ovf_div_err got %b exp 1", bus.div_err); end
        checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL ovf_div_q_held got %h exp 03", bus.quotient); end
        checks++; if (bus.remainder !== 8'hFF) begin errors++; $display("FAIL ovf_div_r_held got %h exp ff", bus.remainder); end
        do_op(1'b1, 16'hFF80, 8'h01, lat, bc);
        checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL ovf_m128_err got %b exp 1", bus.div_err); end
        checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL ovf_m128_q_held got %h exp 03", bus.quotient); end
        do_op(1'b1, 16'hFF81, 8'h01, lat, bc);
        checks++; if (bus.div_err !== 1'b0) begin errors++; $display("FAIL ovf_m127_err got %b exp 0", bus.div_err); end
        checks++; if (bus.quotient !== 8'h81) begin errors++; $display("FAIL ovf_m127_q got %h exp 81", bus.quotient); end
        checks++; if (bus.remainder !== 8'h00) begin errors++; $display("FAIL ovf_m127_r got %h exp 00", bus.remainder); end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        do_op(1'b0, 16'h1234, 8'h00, lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dz_lat got %0d exp 2", lat); end
        checks++; if (bc !== 2) begin errors++; $display("FAIL dz_busy got %0d exp 2", bc); end
        checks++; if (bus.div_err !== 1'b1) begin errors++; $display("FAIL dz_err got %b exp 1", bus.div_err); end
        checks++; if (bus.quotient !== 8'h81) begin errors++; $display("FAIL dz_q_held got %h exp 81", bus.quotient); end
    endtask

    task automatic test_busy_ignored;
        int lat, quiet;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 16'h0064; bus.divisor = 8'h0A;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'h0010; bus.divisor = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bi_done got %b exp 1", bus.done); end
        checks++; if (bus.quotient !== 8'h0A) begin errors++; $display("FAIL bi_q got %h exp 0a", bus.quotient); end
        quiet = 0;
        repeat (5) begin @(posedge clk); #1; if (!bus.busy && !bus.done) quiet++; end
        checks++; if (quiet !== 5) begin errors++; $display("FAIL bi_no_queue got %0d idle cycles exp 5", quiet); end
    endtask

    task automatic test_back_to_back;
        int acc, dn, first_done, second_acc, lat;
        logic pb;
        acc = 0; dn = 0; first_done = -1; second_acc = -1; pb = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 16'h004B; bus.divisor = 8'h19;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dn++;
                if (first_done < 0) first_done = i;
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy got %b exp 0", bus.busy); end
            end
            if (bus.busy && !pb) begin acc++; if (acc == 2) second_acc = i; end
            pb = bus.busy;
        end
        bus.start = 1'b0;
        checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc); end
        checks++; if (first_done !== 18) begin errors++; $display("FAIL b2b_first_done got %0d exp 18", first_done); end
        checks++; if (second_acc !== 19) begin errors++; $display("FAIL b2b_second_acc got %0d exp 19", second_acc); end
        lat = 0;
        while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
        if (bus.done) dn++;
        checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_dones got %0d exp 2", dn); end
        checks++; if (bus.quotient !== 8'h03) begin errors++; $display("FAIL b2b_q got %h exp 03", bus.quotient); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_extra_accept got busy %b exp 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int dn, lat, bc;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 16'h004B; bus.divisor = 8'h19;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
        checks++; if (bus.quotient !== 8'h00) begin errors++; $display("FAIL rm_q got %h exp 00", bus.quotient); end
        checks++; if (bus.remainder !== 8'h00) begin errors++; $display("FAIL rm_r got %h exp 00", bus.remainder); end
        @(posedge clk); #1 rst_n = 1'b1;
        dn = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", dn); end
        do_op(1'b0, 16'h00FF, 8'h10, lat, bc);
        checks++; if (lat !== 18) begin errors++; $display("FAIL rm_next_lat got %0d exp 18", lat); end
        checks++; if (bus.quotient !== 8'h0F) begin errors++; $display("FAIL rm_next_q got %h exp 0f", bus.quotient); end
        checks++; if (bus.remainder !== 8'h0F) begin errors++; $display("FAIL rm_next_r got %h exp 0f", bus.remainder); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_div;
        test_idiv;
        test_overflow;
        test_div_zero;
        test_busy_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
